// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if: control, config handshake and divided outputs of the divider bank
interface clk_div_bank_if #(
  parameter int CH   = 4,
  parameter int SELW = 2,
  parameter int CW   = 25
);
  logic [CH-1:0]   en;
  logic [CH-1:0]   mode;
  logic            sync;
  logic            cfg_valid;
  logic [SELW-1:0] cfg_ch;
  logic [CW-1:0]   cfg_div;
  logic            cfg_ready;
  logic [CH-1:0]   clk_out;
  logic [CH-1:0]   tick;
  modport master (
    output en, mode, sync, cfg_valid, cfg_ch, cfg_div,
    input  cfg_ready, clk_out, tick
  );
  modport slave (
    input  en, mode, sync, cfg_valid, cfg_ch, cfg_div,
    output cfg_ready, clk_out, tick
  );
endinterface

// File: rtl/clk_div_bank.sv
// clk_div_bank: CH independent programmable toggle/tick dividers with wrap-aligned divisor updates
module clk_div_bank #(
  parameter int CH      = 4,
  parameter int SELW    = 2,
  parameter int CW      = 25,
  parameter int DEF_DIV = 50
) (
  input logic          clk,
  input logic          reset,
  clk_div_bank_if.slave bus
);
  localparam int N = 1 << SELW;
  logic [CH-1:0][CW-1:0] cnt_q, cnt_d, div_q, div_d, shadow_q, shadow_d;
  logic [CH-1:0]         pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, acc, wrap;
  logic [N-1:0]          pend_ext;
  assign pend_ext      = N'(pend_q);
  assign bus.cfg_ready = ~pend_ext[bus.cfg_ch];
  assign bus.clk_out   = clk_q;
  assign bus.tick      = tick_q;
  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign acc[g]  = bus.cfg_valid && bus.cfg_ready && bus.cfg_ch == SELW'(g);
    assign wrap[g] = bus.en[g] && cnt_q[g] == div_q[g];
  end
  // per-channel next state: sync restarts everything, otherwise count/wrap, apply pending, then accept
  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    clk_d    = '0;
    tick_d   = '0;
    for (int i = 0; i < CH; i++) begin
      if (bus.sync) begin
        cnt_d[i]    = '0;
        div_d[i]    = acc[i] ? bus.cfg_div : pend_q[i] ? shadow_q[i] : div_q[i];
        shadow_d[i] = acc[i] ? bus.cfg_div : shadow_q[i];
        pend_d[i]   = 1'b0;
      end else begin
        tick_d[i] = wrap[i];
        clk_d[i]  = ~bus.mode[i] & (wrap[i] ^ clk_q[i]);
        cnt_d[i]  = wrap[i] ? '0 : bus.en[i] ? cnt_q[i] + CW'(1) : pend_q[i] ? '0 : cnt_q[i];
        if ((wrap[i] || !bus.en[i]) && pend_q[i]) begin
          div_d[i]  = shadow_q[i];
          pend_d[i] = 1'b0;
        end
        if (acc[i]) begin
          shadow_d[i] = bus.cfg_div;
          pend_d[i]   = 1'b1;
        end
      end
    end
  end
  // channel state registers, cleared asynchronously to the default divisor
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q    <= '0;
      div_q    <= {CH{CW'(DEF_DIV)}};
      shadow_q <= '0;
      pend_q   <= '0;
      clk_q    <= '0;
      tick_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed checks of the divider bank against hand-computed cycle timelines
module tb_clk_div_bank;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  clk_div_bank_if #(.CH(4), .SELW(3), .CW(25)) bus ();
  clk_div_bank #(.CH(4), .SELW(3), .CW(25), .DEF_DIV(50)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tickn(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.en = 4'hF;
    bus.mode = 4'h0;
    bus.sync = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch = 3'd0;
    bus.cfg_div = '0;
    #2;
    chk("rst_clk", 32'(bus.clk_out), 32'h0);
    chk("rst_tick", 32'(bus.tick), 32'h0);
    chk("rst_ready", 32'(bus.cfg_ready), 32'h1);
    @(posedge clk);
    #3 reset = 1'b0;
    tickn(50);
    chk("e50_clk", 32'(bus.clk_out), 32'h0);
    chk("e50_tick", 32'(bus.tick), 32'h0);
    tickn(1);
    chk("e51_clk", 32'(bus.clk_out), 32'hF);
    chk("e51_tick", 32'(bus.tick), 32'hF);
    tickn(1);
    chk("e52_tick", 32'(bus.tick), 32'h0);
    chk("e52_clk", 32'(bus.clk_out), 32'hF);
    tickn(50);
    chk("e102_tick", 32'(bus.tick), 32'hF);
    chk("e102_clk", 32'(bus.clk_out), 32'h0);
    tickn(10);
    bus.cfg_valid = 1'b1;
    bus.cfg_ch = 3'd1;
    bus.cfg_div = 25'd3;
    #1 chk("wr1_ready_pre", 32'(bus.cfg_ready), 32'h1);
    tickn(1);
    bus.cfg_valid = 1'b0;
    chk("wr1_ready_low", 32'(bus.cfg_ready), 32'h0);
    tickn(39);
    chk("e152_ready", 32'(bus.cfg_ready), 32'h0);
    chk("e152_tick", 32'(bus.tick), 32'h0);
    tickn(1);
    chk("e153_tick", 32'(bus.tick), 32'hF);
    chk("e153_clk", 32'(bus.clk_out), 32'hF);
    chk("e153_ready", 32'(bus.cfg_ready), 32'h1);
    tickn(3);
    chk("e156_tick", 32'(bus.tick), 32'h0);
    tickn(1);
    chk("e157_tick", 32'(bus.tick), 32'h2);
    chk("e157_clk", 32'(bus.clk_out), 32'hD);
    tickn(4);
    chk("e161_tick", 32'(bus.tick), 32'h2);
    chk("e161_clk", 32'(bus.clk_out), 32'hF);
    bus.mode = 4'b0100;
    bus.cfg_valid = 1'b1;
    bus.cfg_ch = 3'd2;
    bus.cfg_div = 25'd0;
    tickn(1);
    bus.cfg_valid = 1'b0;
    chk("e162_clk", 32'(bus.clk_out), 32'hB);
    chk("e162_tick", 32'(bus.tick), 32'h0);
    chk("e162_ready2", 32'(bus.cfg_ready), 32'h0);
    tickn(42);
    chk("e204_tick", 32'(bus.tick), 32'hD);
    chk("e204_clk", 32'(bus.clk_out), 32'h2);
    chk("e204_ready2", 32'(bus.cfg_ready), 32'h1);
    tickn(1);
    chk("e205_tick", 32'(bus.tick), 32'h6);
    chk("e205_clk", 32'(bus.clk_out), 32'h0);
    tickn(1);
    chk("e206_tick", 32'(bus.tick), 32'h4);
    bus.en = 4'b0111;
    tickn(10);
    chk("e216_tick", 32'(bus.tick), 32'h4);
    chk("e216_clk", 32'(bus.clk_out), 32'h0);
    bus.en = 4'hF;
    tickn(39);
    chk("e255_tick", 32'(bus.tick), 32'h5);
    chk("e255_clk", 32'(bus.clk_out), 32'h1);
    tickn(9);
    chk("e264_tick", 32'(bus.tick), 32'h4);
    tickn(1);
    chk("e265_tick", 32'(bus.tick), 32'hE);
    chk("e265_clk", 32'(bus.clk_out), 32'hB);
    bus.sync = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_ch = 3'd0;
    bus.cfg_div = 25'd2;
    #1 chk("sync_ready_pre", 32'(bus.cfg_ready), 32'h1);
    tickn(1);
    bus.sync = 1'b0;
    bus.cfg_valid = 1'b0;
    chk("sync_clk", 32'(bus.clk_out), 32'h0);
    chk("sync_tick", 32'(bus.tick), 32'h0);
    chk("sync_ready0", 32'(bus.cfg_ready), 32'h1);
    tickn(2);
    chk("e268_tick", 32'(bus.tick), 32'h4);
    chk("e268_clk", 32'(bus.clk_out), 32'h0);
    tickn(1);
    chk("e269_tick", 32'(bus.tick), 32'h5);
    chk("e269_clk", 32'(bus.clk_out), 32'h1);
    tickn(1);
    chk("e270_tick", 32'(bus.tick), 32'h6);
    chk("e270_clk", 32'(bus.clk_out), 32'h3);
    bus.cfg_valid = 1'b1;
    bus.cfg_ch = 3'd5;
    bus.cfg_div = 25'd7;
    #1 chk("ch5_ready", 32'(bus.cfg_ready), 32'h1);
    tickn(1);
    bus.cfg_valid = 1'b0;
    bus.cfg_ch = 3'd0;
    #1 chk("ch5_ready0", 32'(bus.cfg_ready), 32'h1);
    bus.cfg_ch = 3'd1;
    #1 chk("ch5_ready1", 32'(bus.cfg_ready), 32'h1);
    tickn(1);
    chk("e272_tick", 32'(bus.tick), 32'h5);
    chk("e272_clk", 32'(bus.clk_out), 32'h2);
    bus.cfg_valid = 1'b1;
    bus.cfg_ch = 3'd3;
    bus.cfg_div = 25'd9;
    tickn(1);
    bus.cfg_valid = 1'b0;
    chk("e273_ready3", 32'(bus.cfg_ready), 32'h0);
    chk("e273_clk", 32'(bus.clk_out), 32'h2);
    chk("e273_tick", 32'(bus.tick), 32'h4);
    #3 reset = 1'b1;
    bus.mode = 4'h0;
    #1;
    chk("arst_clk", 32'(bus.clk_out), 32'h0);
    chk("arst_tick", 32'(bus.tick), 32'h0);
    chk("arst_ready", 32'(bus.cfg_ready), 32'h1);
    #2 reset = 1'b0;
    tickn(50);
    chk("post_e50_clk", 32'(bus.clk_out), 32'h0);
    chk("post_e50_tick", 32'(bus.tick), 32'h0);
    tickn(1);
    chk("post_e51_clk", 32'(bus.clk_out), 32'hF);
    chk("post_e51_tick", 32'(bus.tick), 32'hF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised multi-channel clock/tick divider. It generalises the single fixed divide-by-102 toggle divider into CH independent channels. Each channel has a runtime-programmable divisor, a per-channel enable, and a toggle or tick output mode. Divisor updates use a valid/ready handshake and are applied glitch-free at the channel's next wrap. The block sits between the board clock and the slow-rate consumers: LED shifters, debouncers and display scanners.

## Interface
- CH, 4, number of divider channels (1..2^SELW)
- SELW, 2, width of channel-select field
- CW, 25, counter and divisor width
- DEF_DIV, 50, divisor loaded into every channel at reset (toggle period 2*(DEF_DIV+1) clk)

- clk  input  1  system clock; all logic is on its rising edge
- reset  input  1  reset, asynchronous, active-high; clears all state
- en  input  CH  per-channel count enable, level-sensitive
- mode  input  CH  per-channel mode: 0 = toggle (clk_out square wave), 1 = tick only (clk_out held 0)
- sync  input  1  synchronous one-cycle restart of all channels
- cfg_valid  input  1  divisor write request
- cfg_ch  input  SELW  target channel; values >= CH are accepted and discarded
- cfg_div  input  CW  new divisor
- cfg_ready  output  1  combinational, = ~pending[cfg_ch] (1 when cfg_ch >= CH)
- clk_out  output  CH  registered divided clock per channel
- tick  output  CH  registered one-cycle pulse per channel wrap

## Operation
- Per channel i, state is: cnt[CW], div[CW], shadow[CW], pending, clk_out[i], tick[i].
- Wrap condition: en[i] && cnt == div.
  - On wrap: cnt <= 0; tick[i] <= 1; clk_out[i] <= mode[i] ? 0 : ~clk_out[i].
  - If pending, also div <= shadow and pending <= 0.
- Non-wrap with en[i]=1: cnt <= cnt+1; tick[i] <= 0.
- en[i]=0: cnt and clk_out[i] hold; tick[i] <= 0.
  - A pending divisor is applied at this edge (div <= shadow, pending <= 0) and cnt <= 0.
- mode[i]=1: clk_out[i] is forced to 0 at the next edge; tick behaviour is unchanged.
- Divisor 0 is legal: tick fires every enabled cycle, and toggle mode gives clk/2.
- cnt never exceeds div, so no counter overflow rule is needed.
- Config accept: cfg_valid && cfg_ready, with cfg_ch < CH. Then shadow <= cfg_div and pending <= 1.
  - While pending=1 for a channel, cfg_ready is 0 for that channel; further writes to it stall.
- sync=1 overrides everything, for all channels:
  - cnt <= 0, clk_out <= 0, tick <= 0.
  - Pending shadows are applied (div <= shadow, pending <= 0).
  - A write accepted in the same cycle loads div directly and leaves pending at 0.
- Priority per channel: reset > sync > wrap/disabled apply > config accept.
  - If an accept and a wrap occur in the same cycle, the wrap uses the old div/shadow state; the new value becomes pending and applies at the following wrap.

## Timing
- Reset values: cnt=0, div=DEF_DIV, shadow=0, pending=0, clk_out=0, tick=0, cfg_ready=1.
- Asynchronous reset mid-period clears the period immediately. The first wrap after release occurs div+1 enabled cycles later.
- tick[i] and the clk_out[i] edge appear together, in the cycle after the edge where cnt==div was sampled.
- Tick period = div+1 enabled cycles. Toggle-mode period = 2*(div+1), 50% duty.
- Divisor latency: the new div takes effect at the first wrap after accept, or at the next edge if en[i]=0 or sync=1. It is never mid-period, so there are no runt pulses.
- cfg_ready reflects pending combinationally: it goes low the cycle after accept and high the cycle after the apply.

## Test plan
- Reset, all channels enabled, mode=0, default config:
  - clk_out[0] first rises at cycle 51 and has period 102.
  - tick pulses every 51 cycles, 1 cycle wide.
  - cfg_ready=1.
- Write cfg_ch=1, cfg_div=3 in the middle of a period:
  - cfg_ready for channel 1 drops next cycle.
  - The old period completes, then channel 1 has tick period 4 and clk_out period 8.
  - cfg_ready rises after the apply.
  - Channels 0, 2 and 3 are undisturbed.
- mode[2]=1 with cfg_div=0:
  - tick[2] is high every cycle.
  - clk_out[2] goes to 0 within 1 cycle and stays 0.
- Drop en[3] for 10 cycles mid-count:
  - cnt and clk_out hold, no ticks.
  - Resuming finishes the remaining count; the wrap is delayed by exactly 10 cycles.
- Write channel 0 and pulse sync in the same cycle:
  - All counters and clk_out clear.
  - Channel 0 uses the new div immediately, with pending=0.
  - A write to cfg_ch=5 (>= CH) is accepted and has no effect.
- Assert reset asynchronously between clock edges during a pending update:
  - All outputs are 0 at once, div returns to DEF_DIV, and cfg_ready=1.
